// File: rtl/imem_program_writer_pkg.sv
// Shared encoder constants: class codes, error codes, writer states and ISA opcodes.
// Opcode values must stay in lockstep with the CPU control decoder.
package imem_program_writer_pkg;

    localparam int WORD_W = 18;

    typedef enum logic [2:0] {
        CLS_RR  = 3'd0,
        CLS_MEM = 3'd1,
        CLS_RI  = 3'd2,
        CLS_S14 = 3'd3,
        CLS_STK = 3'd4,
        CLS_INC = 3'd5
    } instr_class_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_CLASS    = 3'd1,
        ERR_IMM      = 3'd2,
        ERR_OPCODE   = 3'd3,
        ERR_POP_REG  = 3'd4,
        ERR_OVERFLOW = 3'd5
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENC   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    // Register-register ALU / move opcodes (RR and MEM classes, word[7:4])
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_SUB    = 4'h3;
    localparam logic [3:0] OP_AND    = 4'h4;
    localparam logic [3:0] OP_OR     = 4'h5;
    localparam logic [3:0] OP_XOR    = 4'h6;
    localparam logic [3:0] OP_LSH    = 4'h7;
    localparam logic [3:0] OP_RSH    = 4'h8;
    localparam logic [3:0] OP_ARSH   = 4'h9;
    localparam logic [3:0] OP_MUL    = 4'hA;
    localparam logic [3:0] OP_FMUL   = 4'hB;
    localparam logic [3:0] OP_MOVR   = 4'hC;
    localparam logic [3:0] OP_MOVMR  = 4'hD;
    localparam logic [3:0] OP_MOVRM  = 4'hE;

    // 14-bit immediate / absolute-address opcodes, op[3:2] is 01 or 10
    localparam logic [3:0] OP_CALL   = 4'h4;
    localparam logic [3:0] OP_MOVMRI = 4'h5;
    localparam logic [3:0] OP_MOVRMI = 4'h6;
    localparam logic [3:0] OP_JL     = 4'h8;
    localparam logic [3:0] OP_JLE    = 4'h9;
    localparam logic [3:0] OP_JNE    = 4'hA;
    localparam logic [3:0] OP_JE     = 4'hB;

    // Stack opcodes, word[17:14]
    localparam logic [3:0] OP_RET    = 4'hC;
    localparam logic [3:0] OP_POP    = 4'hD;
    localparam logic [3:0] OP_PUSH   = 4'hE;
    localparam logic [3:0] OP_PUSHI  = 4'hF;

    // Increment/decrement opcodes, word[17:12]
    localparam logic [5:0] OP_INCR   = 6'h30;
    localparam logic [5:0] OP_DECR   = 6'h31;

    function automatic logic fits_signed(input logic [15:0] value, input int bits);
        int v;
        v = int'($signed(value));
        return (v >= -(1 << (bits - 1))) && (v < (1 << (bits - 1)));
    endfunction

endpackage

// File: rtl/imem_program_writer_if.sv
// Descriptor handshake between the boot/debug loader (master) and the program writer (slave).
interface imem_program_writer_if;

    logic        valid;
    logic        ready;
    logic [2:0]  cls;
    logic [5:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        last;

    modport master (
        output valid, cls, op, rd, rs, imm, last,
        input  ready
    );

    modport slave (
        input  valid, cls, op, rd, rs, imm, last,
        output ready
    );

endinterface

// File: rtl/imem_program_writer_instr_pack.sv
// Combinational packer: descriptor fields -> 18-bit instruction word plus first-found error code.
// Opcode legality is checked before register or immediate range.
module imem_program_writer_instr_pack
    import imem_program_writer_pkg::*;
(
    input  logic [2:0]        i_class,
    input  logic [5:0]        i_op,
    input  logic [3:0]        i_rd,
    input  logic [3:0]        i_rs,
    input  logic [15:0]       i_imm,
    output logic [WORD_W-1:0] o_word,
    output logic [2:0]        o_err_code
);

    logic [3:0] w_op4;

    assign w_op4 = i_op[3:0];

    always_comb begin
        o_word     = '0;
        o_err_code = ERR_NONE;
        case (i_class)
            CLS_RR: begin
                o_word = {2'b00, 4'b0000, i_rd, w_op4, i_rs};
            end
            CLS_MEM: begin
                o_word = {2'b00, 4'b0001, i_rd, w_op4, i_rs};
                if (w_op4 != OP_MOVMR && w_op4 != OP_MOVRM)
                    o_err_code = ERR_OPCODE;
            end
            CLS_RI: begin
                // 0000/0001 in word[15:12] would decode as RR/MEM
                o_word = {2'b00, w_op4, i_rd, i_imm[7:0]};
                if (w_op4 == 4'b0000 || w_op4 == 4'b0001)
                    o_err_code = ERR_OPCODE;
                else if (!fits_signed(i_imm, 8))
                    o_err_code = ERR_IMM;
            end
            CLS_S14: begin
                o_word = {w_op4, i_imm[13:0]};
                if (w_op4[3:2] != 2'b01 && w_op4[3:2] != 2'b10)
                    o_err_code = ERR_OPCODE;
                else if (!fits_signed(i_imm, 14))
                    o_err_code = ERR_IMM;
            end
            CLS_STK: begin
                o_word = {w_op4, i_rd, 10'b0};
                if (w_op4 != OP_POP && w_op4 != OP_PUSH && w_op4 != OP_PUSHI)
                    o_err_code = ERR_OPCODE;
                else if (w_op4 == OP_POP && (i_rd == 4'd12 || i_rd == 4'd13))
                    o_err_code = ERR_POP_REG;
            end
            CLS_INC: begin
                o_word = {i_op, i_rd, 8'b0};
                if (i_op != OP_INCR && i_op != OP_DECR)
                    o_err_code = ERR_OPCODE;
            end
            default: begin
                o_err_code = ERR_CLASS;
            end
        endcase
    end

endmodule

// File: rtl/imem_program_writer.sv
// Program writer: accepts descriptors, encodes them and writes IMEM sequentially (1 word / 3 cycles).
// Optional feature macro IMEM_CHECKSUM_EN builds a running XOR of every written word.
module imem_program_writer
    import imem_program_writer_pkg::*;
#(
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] DEPTH  = 16'hFFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    imem_program_writer_if.slave  s_desc,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    output logic                  o_imem_we,
    output logic [ADDR_W-1:0]     o_imem_addr,
    output logic [WORD_W-1:0]     o_imem_wdata,
    output logic [15:0]           o_word_count,
    output logic                  o_err,
    output logic [2:0]            o_err_code,
    output logic                  o_done,
    output logic [WORD_W-1:0]     o_checksum
);

    wr_state_e         r_state;
    wr_state_e         w_state_nxt;
    // Extra MSB lets the address step past DEPTH without wrapping back to 0
    logic [ADDR_W:0]   r_addr;
    logic [15:0]       r_count;
    logic [WORD_W-1:0] r_word;
    logic              r_desc_err;
    logic              r_last;
    logic              r_ready;
    logic              r_err;
    logic [2:0]        r_err_code;

    logic [WORD_W-1:0] w_pack_word;
    logic [2:0]        w_pack_err;
    logic [2:0]        w_desc_err;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_imem_we;

    imem_program_writer_instr_pack u_pack (
        .i_class    (s_desc.cls),
        .i_op       (s_desc.op),
        .i_rd       (s_desc.rd),
        .i_rs       (s_desc.rs),
        .i_imm      (s_desc.imm),
        .o_word     (w_pack_word),
        .o_err_code (w_pack_err)
    );

    assign w_start_ok = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_accept   = (r_state == ST_IDLE) && r_ready && s_desc.valid && !i_start;
    assign w_desc_err = (w_pack_err != ERR_NONE)   ? w_pack_err   :
                        (r_addr > {1'b0, DEPTH})   ? ERR_OVERFLOW : ERR_NONE;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_imem_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = ST_ENC;
            end
            ST_ENC: begin
                if (r_desc_err)
                    w_state_nxt = r_last ? ST_DONE : ST_IDLE;
                else
                    w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_imem_we   = 1'b1;
                w_state_nxt = r_last ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (w_start_ok)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_desc_err <= 1'b0;
            r_last     <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE);
            if (w_start_ok) begin
                r_addr     <= {1'b0, i_base_addr};
                r_count    <= '0;
                r_err      <= 1'b0;
                r_err_code <= '0;
            end else if (w_accept) begin
                r_word     <= w_pack_word;
                r_last     <= s_desc.last;
                r_desc_err <= (w_desc_err != ERR_NONE);
                if (w_desc_err != ERR_NONE) begin
                    r_err <= 1'b1;
                    if (!r_err)
                        r_err_code <= w_desc_err;
                end
            end
            if (w_imem_we) begin
                r_addr  <= r_addr + (ADDR_W + 1)'(1);
                r_count <= r_count + 16'd1;
            end
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [WORD_W-1:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_checksum <= '0;
        else if (w_start_ok)
            r_checksum <= '0;
        else if (w_imem_we)
            r_checksum <= r_checksum ^ r_word;
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = '0;
`endif

    assign s_desc.ready = r_ready;
    assign o_imem_we    = w_imem_we;
    assign o_imem_addr  = r_addr[ADDR_W] ? '1 : r_addr[ADDR_W-1:0];
    assign o_imem_wdata = r_word;
    assign o_word_count = r_count;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    assign o_done       = (r_state == ST_DONE);

endmodule
